mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//  Upstream select sequencer for the 4:1 mux_cct datapath. Drives c1:c0, waits a settle
//  (dwell) time per channel, samples mux output m, and builds a 4-bit snapshot of all
//  enabled inputs. Start/busy/done handshake lets a host trigger one scan at a time.
// PARAMETERS
//  DWELL     3      settle cycles per channel before sampling m; legal range 1..255
//  CNT_W     8      dwell counter width; must satisfy DWELL <= 2**CNT_W-1
// PORTS
//  clk       in   1  single clock; all state updates on rising edge
//  rst       in   1  synchronous, active-high reset
//  start     in   1  one-cycle scan request; honoured only in IDLE
//  abort     in   1  synchronous scan cancel; honoured in any non-IDLE state
//  ch_mask   in   4  channel enables, bit i = input x_i; latched on accepted start
//  m         in   1  mux output fed back from mux_cct
//  c0        out  1  select LSB to mux_cct
//  c1        out  1  select MSB to mux_cct
//  busy      out  1  high from the cycle after an accepted start until DONE
//  done      out  1  one-cycle pulse; result valid and stable from that cycle
//  result    out  4  bit i = m sampled with select i; 0 for masked channels
// BEHAVIOUR
//  Reset values: c1:c0=00, busy=0, done=0, result=0000, state IDLE, latched mask=0000.
//  States: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE: c1:c0=00. start & |ch_mask -> latch mask, ch = lowest set bit, cnt = DWELL-1,
//    clear result, go SETTLE. start & ch_mask==0 -> clear result, go DONE.
//  - SETTLE: c1:c0 = ch. cnt==0 -> SAMPLE, else cnt--.
//  - SAMPLE: result[ch] <= m. If a higher enabled channel exists, ch = next set bit
//    above ch, cnt = DWELL-1, go SETTLE. Otherwise go DONE.
//  - DONE: done=1, busy=0, c1:c0 holds last ch. Next cycle -> IDLE.
//  busy=1 in SETTLE and SAMPLE only.
//  Latency: with k enabled channels, DONE is k*(DWELL+1)+1 cycles after the start edge.
//  Example: k=4, DWELL=3 gives 17 cycles.
//  Channel order is strictly ascending (0->3). No wrap-around in a scan.
//  Masked channels are never selected.
//  start while not IDLE is ignored. ch_mask changes after latch have no effect.
//  abort in SETTLE/SAMPLE -> IDLE next cycle, no done pulse. Bits already sampled are kept.
//  abort in DONE: done still pulses that cycle, then IDLE.
//  abort has priority over the state's normal transition. rst has priority over abort.
//  start and abort together in IDLE: the start is accepted, because abort is ignored in IDLE.
//  rst mid-scan: all outputs return to reset values on the next edge.
//  result changes only in SAMPLE and on scan acceptance (clear).
// STRUCTURE
//  Shared include mux_scan_defs.vh holds:
//  - state encodings (2-bit: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//  - channel count (4) and select width (2)
//  Sub-module mux_scan_next_ch is combinational: given mask[3:0] and current ch,
//  returns the next set bit strictly above ch plus a found flag. The IDLE path reuses it
//  with ch = -1 (lowest set bit).
//  Top holds the FSM, dwell counter, mask/result registers and select output register.
// TESTING (DWELL=3 unless noted)
//  1. Tie x=1011 (x0=1,x1=1,x2=0,x3=1); mask=1111; pulse start ->
//     selects 00,01,10,11 each held 4 cycles; done at cycle 17; result=1011.
//  2. mask=0100, x2=1 -> only c1:c0=10 driven; done at cycle 5; result=0100.
//  3. mask=0000, start -> done next cycle (cycle 1); busy never high; result=0000.
//  4. mask=1111; abort at cycle 6 (channel 1 settling) ->
//     IDLE at cycle 7, no done, result=000(x0); next start scans fully.
//  5. rst at cycle 9 mid-scan -> next cycle c1:c0=00, busy=0, result=0000.
//     start pulses during busy are ignored (no restart, same done cycle).
//  6. DWELL=1, mask=1010 -> selects 01 then 11 (2 cycles each); done at cycle 5;
//     changing ch_mask mid-scan has no effect.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module : mux_scan_pkg
// Brief  : Shared state encoding and channel geometry for the mux scan sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam int c_num_ch = 4;
  localparam int c_sel_w  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
// ============================================================================
// Module : mux_scan_next_ch
// Brief  : Finds the next enabled channel strictly above ch (or the lowest one)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [c_num_ch-1:0] mask,
  input  logic [c_sel_w-1:0]  ch,
  input  logic                from_start,
  output logic [c_sel_w-1:0]  next_ch,
  output logic                found
);

  // Descending walk so the last hit written is the lowest qualifying channel;
  // from_start acts as ch = -1.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = c_num_ch - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(ch)))) begin
        next_ch = c_sel_w'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module : mux_scan_ctrl
// Brief  : Select sequencer that dwells on each enabled mux channel and samples m
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [c_num_ch-1:0] ch_mask,
  input  logic                m,
  output logic                c0,
  output logic                c1,
  output logic                busy,
  output logic                done,
  output logic [c_num_ch-1:0] result
);

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(DWELL - 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [c_sel_w-1:0]  r_ch, w_ch_nxt, w_next_ch;
  logic [c_num_ch-1:0] r_mask, w_mask_nxt;
  logic [c_num_ch-1:0] r_result, w_result_nxt;
  logic [c_num_ch-1:0] w_scan_mask;
  logic                w_first, w_found;

  // In IDLE the search runs on the live mask so the first channel is known at acceptance.
  assign w_first     = (r_state == ST_IDLE);
  assign w_scan_mask = w_first ? ch_mask : r_mask;

  mux_scan_next_ch u_next_ch (
    .mask       (w_scan_mask),
    .ch         (r_ch),
    .from_start (w_first),
    .next_ch    (w_next_ch),
    .found      (w_found)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ch_nxt     = r_ch;
    w_mask_nxt   = r_mask;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_result_nxt = '0;
          if (w_found) begin
            w_mask_nxt  = ch_mask;
            w_ch_nxt    = w_next_ch;
            w_cnt_nxt   = c_cnt_init;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_ch_nxt    = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          w_ch_nxt    = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_result_nxt[r_ch] = m;
          if (w_found) begin
            w_ch_nxt    = w_next_ch;
            w_cnt_nxt   = c_cnt_init;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_ch_nxt    = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_ch_nxt    = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ch     <= '0;
      r_mask   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ch     <= w_ch_nxt;
      r_mask   <= w_mask_nxt;
      r_result <= w_result_nxt;
    end
  end

  // The channel register doubles as the select output; it is zero whenever IDLE.
  assign c1     = r_ch[1];
  assign c0     = r_ch[0];
  assign busy   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module : tb_mux_scan_ctrl
// Brief  : Scoreboard bench for mux_scan_ctrl with a behavioural 4:1 mux model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int MAX_CYC = 24;

  typedef struct {
    logic [3:0] res;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, abort, use_d1;
  logic [3:0] ch_mask, x;

  wire        start_a = start & ~use_d1;
  wire        start_b = start & use_d1;
  wire        c0_a, c1_a, busy_a, done_a, m_a;
  wire        c0_b, c1_b, busy_b, done_b, m_b;
  wire  [3:0] result_a, result_b;

  wire  [1:0] obs_sel    = use_d1 ? {c1_b, c0_b} : {c1_a, c0_a};
  wire        obs_busy   = use_d1 ? busy_b : busy_a;
  wire        obs_done   = use_d1 ? done_b : done_a;
  wire  [3:0] obs_result = use_d1 ? result_b : result_a;

  assign m_a = x[{c1_a, c0_a}];
  assign m_b = x[{c1_b, c0_b}];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .ch_mask(ch_mask), .m(m_a),
    .c0(c0_a), .c1(c1_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut_d1 (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .ch_mask(ch_mask), .m(m_b),
    .c0(c0_b), .c1(c1_b), .busy(busy_b), .done(done_b), .result(result_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  exp_t        e;
  int          done_cyc, done_cnt, busy_cnt;
  logic [3:0]  done_res, probe_res;
  logic [1:0]  done_sel, probe_sel;
  logic        probe_busy, probe_done;
  logic [63:0] sel_pack;

  function automatic int exp_lat(input logic [3:0] mask, input int dwell);
    return $countones(mask) * (dwell + 1) + 1;
  endfunction

  function automatic logic [63:0] exp_sel_pack(input logic [3:0] mask, input int dwell);
    logic [63:0] p = '0;
    for (int i = 0; i < 4; i++)
      if (mask[i])
        for (int r = 0; r <= dwell; r++) p = {p[61:0], 2'(i)};
    return p;
  endfunction

  // Drives one scan request in cycle 0 and records what the selected DUT does.
  task automatic run_scan(input logic [3:0] mask, input int abort_cyc, input int rst_cyc,
                          input int probe_cyc, input int chg_cyc, input logic [3:0] mask2,
                          input bit restarts);
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; sel_pack = '0;
    done_res = 'x; done_sel = 'x;
    ch_mask = mask; start = 1'b1; abort = (abort_cyc == 0);
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      if (obs_busy) begin busy_cnt++; sel_pack = {sel_pack[61:0], obs_sel}; end
      if (obs_done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; done_res = obs_result; done_sel = obs_sel; end
      end
      if (c == probe_cyc) begin
        probe_sel = obs_sel; probe_busy = obs_busy; probe_done = obs_done; probe_res = obs_result;
      end
      if (c == chg_cyc)   ch_mask = mask2;
      if (c == abort_cyc) abort = 1'b1;
      if (c == rst_cyc)   rst = 1'b1;
      if (restarts && obs_busy) start = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = 4'hF; x = 4'hF; use_d1 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (obs_sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b expected 00", obs_sel); end
    n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", obs_busy); end
    n_tests++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", obs_done); end
    n_tests++; if (obs_result !== 4'b0000) begin n_fail++; $display("FAIL reset_result: got %b expected 0000", obs_result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    x = 4'b1011;
    exp_q.push_back('{res: x & 4'b1111, cyc: exp_lat(4'b1111, 3)});
    run_scan(4'b1111, -1, -1, 18, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected %0d", done_cyc, e.cyc); end
    n_tests++; if (done_res !== e.res) begin n_fail++; $display("FAIL full_result: got %b expected %b", done_res, e.res); end
    n_tests++; if (sel_pack !== exp_sel_pack(4'b1111, 3)) begin n_fail++; $display("FAIL full_select_seq: got %h expected %h", sel_pack, exp_sel_pack(4'b1111, 3)); end
    n_tests++; if (busy_cnt !== e.cyc - 1) begin n_fail++; $display("FAIL full_busy_cycles: got %0d expected %0d", busy_cnt, e.cyc - 1); end
    n_tests++; if (done_sel !== 2'b11) begin n_fail++; $display("FAIL full_sel_at_done: got %b expected 11", done_sel); end
    n_tests++; if (probe_sel !== 2'b00 || probe_done !== 1'b0) begin n_fail++; $display("FAIL full_idle_after: sel %b done %b expected 00 0", probe_sel, probe_done); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_single_channel();
    x = 4'b0100;
    exp_q.push_back('{res: x & 4'b0100, cyc: exp_lat(4'b0100, 3)});
    run_scan(4'b0100, -1, -1, -1, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected %0d", done_cyc, e.cyc); end
    n_tests++; if (done_res !== e.res) begin n_fail++; $display("FAIL single_result: got %b expected %b", done_res, e.res); end
    n_tests++; if (sel_pack !== exp_sel_pack(4'b0100, 3)) begin n_fail++; $display("FAIL single_select_seq: got %h expected %h", sel_pack, exp_sel_pack(4'b0100, 3)); end
  endtask

  task automatic test_empty_mask();
    x = 4'b1111;
    exp_q.push_back('{res: 4'b0000, cyc: exp_lat(4'b0000, 3)});
    run_scan(4'b0000, -1, -1, -1, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc) begin n_fail++; $display("FAIL empty_done_cycle: got %0d expected %0d", done_cyc, e.cyc); end
    n_tests++; if (done_res !== e.res) begin n_fail++; $display("FAIL empty_result: got %b expected %b", done_res, e.res); end
    n_tests++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_abort();
    x = 4'b1011;
    exp_q.push_back('{res: x & 4'b0001, cyc: -1});
    run_scan(4'b1111, 6, -1, 7, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
    n_tests++; if (probe_busy !== 1'b0 || probe_sel !== 2'b00) begin n_fail++; $display("FAIL abort_idle: busy %b sel %b expected 0 00", probe_busy, probe_sel); end
    n_tests++; if (probe_res !== e.res) begin n_fail++; $display("FAIL abort_kept_bits: got %b expected %b", probe_res, e.res); end

    exp_q.push_back('{res: x & 4'b1111, cyc: exp_lat(4'b1111, 3)});
    run_scan(4'b1111, -1, -1, -1, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc || done_res !== e.res) begin n_fail++; $display("FAIL abort_rescan: cycle %0d result %b expected %0d %b", done_cyc, done_res, e.cyc, e.res); end

    x = 4'b0100;
    exp_q.push_back('{res: x & 4'b0100, cyc: exp_lat(4'b0100, 3)});
    run_scan(4'b0100, 5, -1, 6, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc || done_res !== e.res) begin n_fail++; $display("FAIL abort_in_done: cycle %0d result %b expected %0d %b", done_cyc, done_res, e.cyc, e.res); end
    n_tests++; if (probe_done !== 1'b0 || probe_busy !== 1'b0) begin n_fail++; $display("FAIL abort_in_done_idle: done %b busy %b expected 0 0", probe_done, probe_busy); end

    exp_q.push_back('{res: x & 4'b0100, cyc: exp_lat(4'b0100, 3)});
    run_scan(4'b0100, 0, -1, -1, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc || done_res !== e.res) begin n_fail++; $display("FAIL start_with_abort: cycle %0d result %b expected %0d %b", done_cyc, done_res, e.cyc, e.res); end
  endtask

  task automatic test_reset_mid_scan();
    x = 4'b0110;
    exp_q.push_back('{res: 4'b0000, cyc: -1});
    run_scan(4'b1111, -1, 9, 10, -1, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (probe_sel !== 2'b00 || probe_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: sel %b busy %b expected 00 0", probe_sel, probe_busy); end
    n_tests++; if (probe_res !== e.res) begin n_fail++; $display("FAIL rst_mid_result: got %b expected %b", probe_res, e.res); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    x = 4'b0110;
    exp_q.push_back('{res: x & 4'b1111, cyc: exp_lat(4'b1111, 3)});
    run_scan(4'b1111, -1, -1, -1, -1, 4'b0000, 1'b1);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected %0d", done_cyc, e.cyc); end
    n_tests++; if (done_res !== e.res) begin n_fail++; $display("FAIL restart_result: got %b expected %b", done_res, e.res); end
    n_tests++; if (done_cnt !== 1 || busy_cnt !== e.cyc - 1) begin n_fail++; $display("FAIL restart_single_scan: pulses %0d busy %0d expected 1 %0d", done_cnt, busy_cnt, e.cyc - 1); end
  endtask

  task automatic test_dwell1_mask_change();
    use_d1 = 1'b1;
    x = 4'b0010;
    exp_q.push_back('{res: x & 4'b1010, cyc: exp_lat(4'b1010, 1)});
    run_scan(4'b1010, -1, -1, -1, 2, 4'b0101, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (done_cyc !== e.cyc) begin n_fail++; $display("FAIL d1_done_cycle: got %0d expected %0d", done_cyc, e.cyc); end
    n_tests++; if (done_res !== e.res) begin n_fail++; $display("FAIL d1_result: got %b expected %b", done_res, e.res); end
    n_tests++; if (sel_pack !== exp_sel_pack(4'b1010, 1)) begin n_fail++; $display("FAIL d1_select_seq: got %h expected %h", sel_pack, exp_sel_pack(4'b1010, 1)); end
    use_d1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_single_channel();
    test_empty_mask();
    test_abort();
    test_reset_mid_scan();
    test_back_to_back();
    test_dwell1_mask_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
